// File: rtl/vc_pop_scheduler_pkg.sv
// Shared types and field-position helpers for the VC pop scheduler.
// Word layout: [DATA_SIZE-1] VC class, [DATA_SIZE-2] destination port, remainder payload.
package vc_pop_scheduler_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    G0    = 2'd1,
    G1    = 2'd2,
    STALL = 2'd3
  } sched_state_e;

  function automatic int vc_bit(input int data_size);
    return data_size - 1;
  endfunction

  function automatic int dest_bit(input int data_size);
    return data_size - 2;
  endfunction

endpackage

// File: rtl/vc_pop_scheduler_sat_counter.sv
// Saturating up-counter: one increment per cycle while inc_i is high, holds at all-ones.
// Synchronous active-low reset; output is the register itself (no extra latency).
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vc_pop_scheduler.sv
// Pops one word per cycle from VC0/VC1 (strict VC0 priority, gated by dest almost_full) into D0/D1.
// Pops are combinational, pushes/data/stall registered (1-cycle latency); VC1 anti-starvation via VC_SCHED_STARVE_GUARD_EN.
module vc_pop_scheduler
  import vc_pop_scheduler_pkg::*;
#(
  parameter int DATA_SIZE    = 10,
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 empty0,
  input  logic                 empty1,
  input  logic [DATA_SIZE-1:0] head0,
  input  logic [DATA_SIZE-1:0] head1,
  input  logic                 afull_d0,
  input  logic                 afull_d1,
  output logic                 pop0,
  output logic                 pop1,
  output logic                 push_d0,
  output logic                 push_d1,
  output logic [DATA_SIZE-3:0] data_out,
  output logic                 stall,
  output logic [CNT_W-1:0]     gnt_cnt0,
  output logic [CNT_W-1:0]     gnt_cnt1
);

  localparam int VC_BIT   = vc_bit(DATA_SIZE);
  localparam int DEST_BIT = dest_bit(DATA_SIZE);
  localparam int PAY_W    = DATA_SIZE - 2;

  sched_state_e     state_q, state_d;
  logic             push_d0_q, push_d0_d;
  logic             push_d1_q, push_d1_d;
  logic [PAY_W-1:0] data_q, data_d;

  logic elig0, elig1;
  logic gnt0, gnt1;
  logic force1;
  logic gnt_dest;

  // The class bit travels with the word but plays no part in routing.
  logic unused_vc_bits;
  assign unused_vc_bits = head0[VC_BIT] ^ head1[VC_BIT];

  assign elig0 = !empty0 && !(head0[DEST_BIT] ? afull_d1 : afull_d0);
  assign elig1 = !empty1 && !(head1[DEST_BIT] ? afull_d1 : afull_d0);

`ifdef VC_SCHED_STARVE_GUARD_EN
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;

  assign force1 = elig1 && (starve_q == SW'(STARVE_LIMIT));

  // Run length of VC0 grants taken while VC1 was waiting; any VC1 grant or VC1 going ineligible resets it.
  always_comb begin
    starve_d = starve_q;
    if (!elig1 || gnt1) begin
      starve_d = '0;
    end else if (gnt0) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`else
  logic [31:0] unused_starve_limit;
  assign unused_starve_limit = STARVE_LIMIT;
  assign force1 = 1'b0;
`endif

  assign gnt0 = reset && elig0 && !force1;
  assign gnt1 = reset && elig1 && !gnt0;

  assign pop0 = gnt0;
  assign pop1 = gnt1;

  assign gnt_dest = gnt0 ? head0[DEST_BIT] : head1[DEST_BIT];

  always_comb begin
    state_d   = IDLE;
    push_d0_d = 1'b0;
    push_d1_d = 1'b0;
    data_d    = data_q;
    if (gnt0 || gnt1) begin
      state_d   = gnt0 ? G0 : G1;
      push_d0_d = !gnt_dest;
      push_d1_d = gnt_dest;
      data_d    = gnt0 ? head0[PAY_W-1:0] : head1[PAY_W-1:0];
    end else if (!empty0 || !empty1) begin
      state_d = STALL;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= IDLE;
      push_d0_q <= 1'b0;
      push_d1_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      push_d0_q <= push_d0_d;
      push_d1_q <= push_d1_d;
      data_q    <= data_d;
    end
  end

  assign push_d0  = push_d0_q;
  assign push_d1  = push_d1_q;
  assign data_out = data_q;
  assign stall    = (state_q == STALL);

  sat_counter #(.CNT_W(CNT_W)) u_gnt_cnt0 (
    .clk_i   (clk),
    .rst_n_i (reset),
    .inc_i   (gnt0),
    .cnt_o   (gnt_cnt0)
  );

  sat_counter #(.CNT_W(CNT_W)) u_gnt_cnt1 (
    .clk_i   (clk),
    .rst_n_i (reset),
    .inc_i   (gnt1),
    .cnt_o   (gnt_cnt1)
  );

endmodule
